alu_cmd_seq: RTL and testbench

Upstream command sequencer for the 4-bit ALU.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives registered a/b/select into the ALU, one operation at a time.
- Picks the active result bus from the six ALU result outputs and returns it, with flags, over a valid/ready response interface.

---
 rtl/alu_cmd_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// Command sequencer for the 4-bit ALU: buffers commands, issues them one at a time,
// and returns the selected result bus with zero/error flags over valid/ready.
module alu_cmd_seq #(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [2:0] cmd_op_i,
   input  logic [3:0] cmd_a_i,
   input  logic [3:0] cmd_b_i,
   output logic [3:0] alu_a_o,
   output logic [3:0] alu_b_o,
   output logic [2:0] alu_select_o,
   input  logic [4:0] alu_add_result_i,
   input  logic [4:0] alu_sub_result_i,
   input  logic [3:0] alu_xor_result_i,
   input  logic [3:0] alu_and_result_i,
   input  logic [3:0] alu_or_result_i,
   input  logic [3:0] alu_invt_result_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [4:0] rsp_data_o,
   output logic [2:0] rsp_op_o,
   output logic       rsp_zero_o,
   output logic       rsp_err_o,
   output logic       busy_o
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [2:0]  SEL_OFF  = 3'b111;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

   state_t        state_q, state_d;
   cmd_t          fifo_q [DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push, pop, empty;

   logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0] alu_select_q, alu_select_d;
   logic       rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
   logic [4:0] rsp_data_q, rsp_data_d;
   logic [2:0] rsp_op_q, rsp_op_d;
   logic [4:0] res_data;
   logic       res_err;

   assign empty       = (count_q == '0);
   assign cmd_ready_o = (count_q != FULL_CNT);
   assign push        = cmd_valid_i && cmd_ready_o;
   assign head        = fifo_q[rd_ptr_q];
   // Pop only where the FSM immediately loads the head into the ALU registers.
   assign pop         = !empty && ((state_q == IDLE) || (state_q == RESP && rsp_ready_i));

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty) state_d = ISSUE;
         ISSUE:   state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = empty ? IDLE : ISSUE;
         default: state_d = IDLE;
      endcase
   end

   // Result selection for the op currently on the ALU select lines.
   always_comb begin
      res_data = '0;
      res_err  = 1'b0;
      case (alu_select_q)
         3'd0:    res_data = alu_add_result_i;
         3'd1:    res_data = alu_sub_result_i;
         3'd2:    res_data = {1'b0, alu_xor_result_i};
         3'd3:    res_data = {1'b0, alu_and_result_i};
         3'd4:    res_data = {1'b0, alu_or_result_i};
         3'd5:    res_data = {1'b0, alu_invt_result_i};
         default: res_err  = 1'b1;
      endcase
   end

   always_comb begin
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_select_d = alu_select_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_op_d     = rsp_op_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      if (state_q == ISSUE) begin
         rsp_valid_d  = 1'b1;
         rsp_op_d     = alu_select_q;
         rsp_data_d   = res_data;
         rsp_zero_d   = (res_data == '0);
         rsp_err_d    = res_err;
         alu_select_d = SEL_OFF;
      end else begin
         if (state_q == RESP && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
         end
         if (pop) begin
            alu_a_d      = head.a;
            alu_b_d      = head.b;
            alu_select_d = head.op;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_select_q <= SEL_OFF;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_op_q     <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_select_q <= alu_select_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_op_q     <= rsp_op_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_select_o = alu_select_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_op_o     = rsp_op_q;
   assign rsp_zero_o   = rsp_zero_q;
   assign rsp_err_o    = rsp_err_q;
   assign busy_o       = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: behavioural ALU on the alu_* bus, directed scenarios and
// a randomized run against a queue-based reference of expected responses.
module tb_alu_cmd_seq;

   logic       clk = 1'b0, rst = 1'b1;
   logic       cmd_valid = 1'b0, cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [3:0] cmd_a = '0, cmd_b = '0;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_select;
   logic [4:0] add_r, sub_r;
   logic [3:0] xor_r, and_r, or_r, invt_r;
   logic       rsp_valid, rsp_ready = 1'b0;
   logic [4:0] rsp_data;
   logic [2:0] rsp_op;
   logic       rsp_zero, rsp_err, busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_cmd_seq #(.DEPTH(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_select_o(alu_select),
      .alu_add_result_i(add_r), .alu_sub_result_i(sub_r),
      .alu_xor_result_i(xor_r), .alu_and_result_i(and_r),
      .alu_or_result_i(or_r), .alu_invt_result_i(invt_r),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_data_o(rsp_data), .rsp_op_o(rsp_op),
      .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err), .busy_o(busy)
   );

   // The ALU drives every bus at once; only select 111 silences it.
   always_comb begin
      add_r = '0; sub_r = '0; xor_r = '0; and_r = '0; or_r = '0; invt_r = '0;
      if (alu_select != 3'b111) begin
         add_r  = {1'b0, alu_a} + {1'b0, alu_b};
         sub_r  = {1'b0, alu_a} - {1'b0, alu_b};
         xor_r  = alu_a ^ alu_b;
         and_r  = alu_a & alu_b;
         or_r   = alu_a | alu_b;
         invt_r = ~alu_a;
      end
   end

   function automatic logic [4:0] ref_data(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int r;
      case (op)
         3'd0:    r = int'(a) + int'(b);
         3'd1:    r = (int'(a) - int'(b) + 32) % 32;
         3'd2:    r = int'(a ^ b);
         3'd3:    r = int'(a & b);
         3'd4:    r = int'(a | b);
         3'd5:    r = 15 - int'(a);
         default: r = 0;
      endcase
      return 5'(r);
   endfunction

   // Expected {data, op, zero, err} for one command.
   function automatic logic [9:0] ref_rsp(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] d;
      d = ref_data(op, a, b);
      return {d, op, d == 5'd0, op >= 3'd6};
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, output bit ok);
      ok = 1'b0;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin
            step();
            ok = 1'b1;
            break;
         end
         step();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [9:0] r, output bit ok);
      ok = 1'b0; r = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid) begin
            r = {rsp_data, rsp_op, rsp_zero, rsp_err};
            step();
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      step(); step();
      total++;
      if ({alu_a, alu_b, alu_select, rsp_valid, rsp_data, rsp_op, rsp_zero, rsp_err, busy} !==
          {4'h0, 4'h0, 3'b111, 1'b0, 5'h00, 3'h0, 1'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_outputs got a=%h b=%h sel=%b v=%b d=%b op=%b z=%b e=%b busy=%b want 0,0,111,0...",
                  alu_a, alu_b, alu_select, rsp_valid, rsp_data, rsp_op, rsp_zero, rsp_err, busy);
      end
      rst = 1'b0;
      step();
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
   endtask

   task automatic test_add_latency();
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'b1010; cmd_b = 4'b0011;
      step();                      // edge N: pushed
      cmd_valid = 1'b0;
      total++;
      if ({alu_select, rsp_valid, busy} !== {3'b111, 1'b0, 1'b1}) begin
         bad++; $display("FAIL lat_after_push got sel=%b v=%b busy=%b want 111,0,1", alu_select, rsp_valid, busy);
      end
      step();                      // edge N+1: popped, ISSUE
      total++;
      if ({alu_select, alu_a, alu_b, rsp_valid} !== {3'b000, 4'b1010, 4'b0011, 1'b0}) begin
         bad++; $display("FAIL lat_issue got sel=%b a=%b b=%b v=%b want 000,1010,0011,0", alu_select, alu_a, alu_b, rsp_valid);
      end
      step();                      // edge N+2: response
      total++;
      if ({rsp_valid, rsp_data, rsp_op, rsp_zero, rsp_err, alu_select} !== {1'b1, 5'b01101, 3'b000, 1'b0, 1'b0, 3'b111}) begin
         bad++; $display("FAIL lat_resp got v=%b d=%b op=%b z=%b e=%b sel=%b want 1,01101,000,0,0,111",
                         rsp_valid, rsp_data, rsp_op, rsp_zero, rsp_err, alu_select);
      end
      step();                      // accepted
      total++;
      if ({rsp_valid, busy, alu_select} !== {1'b0, 1'b0, 3'b111}) begin
         bad++; $display("FAIL lat_done got v=%b busy=%b sel=%b want 0,0,111", rsp_valid, busy, alu_select);
      end
   endtask

   task automatic test_sub();
      logic [9:0] r;
      bit ok, ok2;
      push_cmd(3'd1, 4'b0011, 4'b1010, ok); get_rsp(r, ok2);
      total++;
      if (!(ok && ok2) || r !== {5'b11001, 3'b001, 1'b0, 1'b0}) begin
         bad++; $display("FAIL sub_borrow got=%b ok=%0d%0d want=%b", r, ok, ok2, {5'b11001, 3'b001, 2'b00});
      end
      push_cmd(3'd1, 4'b0101, 4'b0101, ok); get_rsp(r, ok2);
      total++;
      if (!(ok && ok2) || r !== {5'b00000, 3'b001, 1'b1, 1'b0}) begin
         bad++; $display("FAIL sub_zero got=%b ok=%0d%0d want=%b", r, ok, ok2, {5'b00000, 3'b001, 2'b10});
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] ops [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
      logic [4:0] exp [4] = '{5'b01001, 5'b00010, 5'b01011, 5'b00101};
      int n_in = 0, n_out = 0, last = 0;
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && n_out < 4; cyc++) begin
         cmd_valid = (n_in < 4);
         cmd_op = ops[n_in % 4]; cmd_a = 4'b1010; cmd_b = 4'b0011;
         if (rsp_valid) begin
            total++;
            if ({rsp_data, rsp_op, rsp_err} !== {exp[n_out], ops[n_out], 1'b0}) begin
               bad++; $display("FAIL b2b_data[%0d] got d=%b op=%b e=%b want d=%b op=%b e=0",
                               n_out, rsp_data, rsp_op, rsp_err, exp[n_out], ops[n_out]);
            end
            if (n_out > 0) begin
               total++;
               if (cyc - last != 2) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d want=2", n_out, cyc - last); end
            end
            last = cyc;
            n_out++;
         end
         if (cmd_valid && cmd_ready) n_in++;
         step();
      end
      cmd_valid = 1'b0;
      total++;
      if (n_out != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", n_out); end
   endtask

   task automatic test_backpressure();
      logic [3:0] a [6], b [6];
      logic [9:0] snap, r;
      int n_in = 0;
      bit ok;
      for (int i = 0; i < 6; i++) begin a[i] = 4'($urandom); b[i] = 4'($urandom); end
      rsp_ready = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         cmd_valid = (n_in < 6);
         cmd_op = 3'd0; cmd_a = a[n_in % 6]; cmd_b = b[n_in % 6];
         if (cmd_valid && cmd_ready) n_in++;
         step();
      end
      cmd_valid = 1'b0;
      total++;
      if (n_in != 5 || cmd_ready !== 1'b0) begin
         bad++; $display("FAIL bp_capacity got accepted=%0d ready=%b want 5,0", n_in, cmd_ready);
      end
      snap = {rsp_data, rsp_op, rsp_zero, rsp_err};
      total++;
      if (rsp_valid !== 1'b1 || snap !== ref_rsp(3'd0, a[0], b[0])) begin
         bad++; $display("FAIL bp_first got v=%b r=%b want 1,%b", rsp_valid, snap, ref_rsp(3'd0, a[0], b[0]));
      end
      step(); step(); step();
      total++;
      if (rsp_valid !== 1'b1 || {rsp_data, rsp_op, rsp_zero, rsp_err} !== snap) begin
         bad++; $display("FAIL bp_stable got v=%b r=%b want 1,%b", rsp_valid, {rsp_data, rsp_op, rsp_zero, rsp_err}, snap);
      end
      rsp_ready = 1'b1;
      step();
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return got=%b want=1", cmd_ready); end
      for (int i = 1; i < 5; i++) begin
         get_rsp(r, ok);
         total++;
         if (!ok || r !== ref_rsp(3'd0, a[i], b[i])) begin
            bad++; $display("FAIL bp_order[%0d] got=%b ok=%0d want=%b", i, r, ok, ref_rsp(3'd0, a[i], b[i]));
         end
      end
   endtask

   task automatic test_illegal();
      logic [2:0] ops [3] = '{3'd6, 3'd0, 3'd7};
      logic [3:0] a, b;
      logic [9:0] r;
      bit ok, ok2;
      for (int i = 0; i < 3; i++) begin
         a = 4'($urandom); b = 4'($urandom);
         push_cmd(ops[i], a, b, ok); get_rsp(r, ok2);
         total++;
         if (!(ok && ok2) || r !== ref_rsp(ops[i], a, b)) begin
            bad++; $display("FAIL illegal_seq[%0d] got=%b ok=%0d%0d want=%b", i, r, ok, ok2, ref_rsp(ops[i], a, b));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] r;
      bit ok, seen;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_cmd(3'd0, 4'($urandom), 4'($urandom), ok);
         total++;
         if (!ok) begin bad++; $display("FAIL rmid_push[%0d] got=timeout want=accepted", i); end
      end
      total++;
      if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rmid_in_resp got v=%b want=1", rsp_valid); end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({rsp_valid, busy, alu_select} !== {1'b0, 1'b0, 3'b111}) begin
         bad++; $display("FAIL rmid_async got v=%b busy=%b sel=%b want 0,0,111", rsp_valid, busy, alu_select);
      end
      step(); step();
      rst = 1'b0;
      rsp_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid || busy) seen = 1'b1;
         step();
      end
      total++;
      if (seen) begin bad++; $display("FAIL rmid_stale got=activity want=none"); end
      push_cmd(3'd0, 4'b0001, 4'b0001, ok); get_rsp(r, ok);
      total++;
      if (!ok || r !== {5'b00010, 3'b000, 1'b0, 1'b0}) begin
         bad++; $display("FAIL rmid_fresh got=%b ok=%0d want=%b", r, ok, {5'b00010, 3'b000, 2'b00});
      end
   endtask

   task automatic test_random();
      logic [9:0] q [$];
      logic [9:0] snap, cur, e;
      bit held = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         cmd_valid = ($urandom_range(0, 1) == 1);
         cmd_op = 3'($urandom_range(0, 7)); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         cur = {rsp_data, rsp_op, rsp_zero, rsp_err};
         if (held) begin
            total++;
            if (rsp_valid !== 1'b1 || cur !== snap) begin
               bad++; $display("FAIL rnd_stable cyc=%0d got v=%b r=%b want 1,%b", cyc, rsp_valid, cur, snap);
            end
         end
         held = 1'b0;
         if (rsp_valid) begin
            if (rsp_ready) begin
               e = (q.size() > 0) ? q.pop_front() : 10'h3ff;
               total++;
               if (cur !== e) begin bad++; $display("FAIL rnd_rsp cyc=%0d got=%b want=%b", cyc, cur, e); end
            end else begin
               held = 1'b1; snap = cur;
            end
         end
         if (cmd_valid && cmd_ready) q.push_back(ref_rsp(cmd_op, cmd_a, cmd_b));
         step();
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      for (int i = 0; i < 100 && q.size() > 0; i++) begin
         if (rsp_valid) begin
            e = q.pop_front();
            total++;
            if ({rsp_data, rsp_op, rsp_zero, rsp_err} !== e) begin
               bad++; $display("FAIL rnd_drain got=%b want=%b", {rsp_data, rsp_op, rsp_zero, rsp_err}, e);
            end
         end
         step();
      end
      step(); step();
      total++;
      if (q.size() != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL rnd_final got left=%0d busy=%b want 0,0", q.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_sub();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
